// File: rtl/pop_window_acc.sv
// Windowed population-count accumulator: counts the active bits of each accepted sample
// and presents the total of every WINDOW samples on a valid/ready output.
// Define POP_WINDOW_ACC_SAT_EN to clamp acc/out_sum at 2^ACC_W-1 instead of wrapping.

module cnt_bits #(
    parameter int IN    = 32,
    parameter bit ACT   = 1'b1,
    parameter int CNT_W = $clog2(IN) + 1
) (
    input  logic [IN-1:0]    data,
    output logic [CNT_W-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < IN; i++) begin
            if (data[i] == ACT) count = count + CNT_W'(1);
        end
    end
endmodule

module pop_window_acc #(
    parameter int IN     = 32,
    parameter bit ACT    = 1'b1,
    parameter int WINDOW = 16,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = $clog2(IN) + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             dbg_state
);
    localparam int SMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    out_state_t       state, state_nxt;
    logic [SMP_W-1:0] smp;
    logic             s1_valid, s1_last;
    logic [CNT_W-1:0] s1_cnt, cnt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf, ovf_sum, carry;
    logic [SUM_W-1:0] sum;
    logic             in_fire, out_fire, s1_adv, retire, retire_last;

    cnt_bits #(.IN(IN), .ACT(ACT), .CNT_W(CNT_W)) u_cnt_bits (
        .data  (in_data),
        .count (cnt)
    );

    // Input stalls only when a last sample is parked in S1 behind an unaccepted result.
    assign in_ready    = reset_ & ~clear & ~(s1_valid & s1_last & out_valid & ~out_ready);
    assign in_fire     = in_valid & in_ready;
    assign out_valid   = (state == FULL);
    assign out_fire    = out_valid & out_ready;
    assign s1_adv      = ~s1_last | ~out_valid | out_ready;
    assign retire      = s1_valid & s1_adv & ~clear;
    assign retire_last = retire & s1_last;
    assign dbg_state   = state;

    assign sum     = {1'b0, acc} + SUM_W'(s1_cnt);
    assign carry   = sum[ACC_W];
    assign ovf_sum = ovf | carry;
`ifdef POP_WINDOW_ACC_SAT_EN
    assign acc_nxt = ovf_sum ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (retire_last) state_nxt = FULL;
            FULL:    if (retire_last) state_nxt = FULL;
                     else if (out_fire) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state    <= EMPTY;
            smp      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cnt   <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                smp      <= '0;
                s1_valid <= 1'b0;
                acc      <= '0;
                ovf      <= 1'b0;
            end else begin
                if (in_fire) begin
                    smp      <= (smp == SMP_LAST) ? '0 : smp + SMP_W'(1);
                    s1_valid <= 1'b1;
                    s1_cnt   <= cnt;
                    s1_last  <= (smp == SMP_LAST);
                end else if (retire) begin
                    s1_valid <= 1'b0;
                end
                if (retire) begin
                    acc <= s1_last ? '0 : acc_nxt;
                    ovf <= s1_last ? 1'b0 : ovf_sum;
                end
            end
            // The result registers only move on retirement, so they hold while FULL.
            if (retire_last) begin
                out_sum <= acc_nxt;
                out_ovf <= ovf_sum;
            end
        end
    end
endmodule

// File: tb/tb_pop_window_acc.sv
// Self-checking bench for pop_window_acc: four instances cover the main, overflow,
// active-low and single-sample-window configurations against a window-level model.

module tb_pop_window_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_, clear, in_valid, out_ready;
    logic [7:0] in_data;
    logic [3:0] ir, ov, oo, st;
    logic [5:0] sum0;
    logic [4:0] sum1;
    logic [5:0] sum2;
    logic [3:0] sum3;

    int         sel;
    logic       m_ir, m_ov, m_oo, m_st;
    logic [7:0] m_os;

`ifdef POP_WINDOW_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    pop_window_acc #(.IN(8), .ACT(1'b1), .WINDOW(4), .ACC_W(6)) u_dut0 (
        .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(sum0),
        .out_ovf(oo[0]), .dbg_state(st[0]));
    pop_window_acc #(.IN(8), .ACT(1'b1), .WINDOW(4), .ACC_W(5)) u_dut1 (
        .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(sum1),
        .out_ovf(oo[1]), .dbg_state(st[1]));
    pop_window_acc #(.IN(8), .ACT(1'b0), .WINDOW(2), .ACC_W(6)) u_dut2 (
        .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(sum2),
        .out_ovf(oo[2]), .dbg_state(st[2]));
    pop_window_acc #(.IN(8), .ACT(1'b1), .WINDOW(1), .ACC_W(4)) u_dut3 (
        .clk(clk), .reset_(reset_), .clear(clear), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_sum(sum3),
        .out_ovf(oo[3]), .dbg_state(st[3]));

    always_comb begin
        m_ir = ir[sel];
        m_ov = ov[sel];
        m_oo = oo[sel];
        m_st = st[sel];
        case (sel)
            0:       m_os = {2'b0, sum0};
            1:       m_os = {3'b0, sum1};
            2:       m_os = {2'b0, sum2};
            default: m_os = {4'b0, sum3};
        endcase
    end

    // Reference model: window totals from plain popcount arithmetic
    int         n_tests = 0;
    int         n_fail = 0;
    int         m_total, m_n;
    logic [8:0] exp_q[$];
    int         p_win[4]  = '{4, 4, 2, 1};
    int         p_accw[4] = '{6, 5, 6, 4};
    bit         p_act[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    function automatic void model_reset();
        m_total = 0;
        m_n = 0;
        exp_q.delete();
    endfunction

    function automatic void model_clear();
        m_total = 0;
        m_n = 0;
    endfunction

    function automatic void model_push(logic [7:0] d);
        int   max_v, s;
        logic ovf;
        m_total += $countones(p_act[sel] ? d : ~d);
        m_n++;
        if (m_n == p_win[sel]) begin
            max_v = (1 << p_accw[sel]) - 1;
            ovf = (m_total > max_v);
            if (!ovf) s = m_total;
            else if (SAT) s = max_v;
            else s = m_total % (max_v + 1);
            exp_q.push_back({ovf, 8'(s)});
            m_total = 0;
            m_n = 0;
        end
    endfunction

    // One clock: inputs already set at the negedge, fires sampled before the posedge.
    task automatic step(output bit ifire, output bit ofire);
        #1;
        ifire = in_valid & m_ir;
        ofire = m_ov & out_ready;
        if (ifire) model_push(in_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_ = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        sel = 0;
        reset_ = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests += 5;
        if (m_ir !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", m_ir); end
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", m_ov); end
        if (m_os !== 8'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", m_os); end
        if (m_oo !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b want 0", m_oo); end
        if (m_st !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0b want 0", m_st); end
        in_valid = 1'b0;
        reset_ = 1'b1;
        #1;
        n_tests++;
        if (m_ir !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", m_ir); end
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_basic();
        logic [7:0] pat[4] = '{8'hFF, 8'h0F, 8'h01, 8'h00};
        bit fi, fo;
        sel = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = pat[i];
            step(fi, fo);
            n_tests++;
            if (!fi) begin n_fail++; $display("FAIL basic_accept: sample %0d not accepted", i); end
        end
        in_valid = 1'b0;
        n_tests++;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL basic_latency: out_valid=%0b at last-fire edge, want 0", m_ov); end
        step(fi, fo);
        n_tests += 2;
        if ({m_ov, m_oo, m_os} !== {1'b1, 1'b0, 8'd13})
            begin n_fail++; $display("FAIL basic_result: valid=%0b ovf=%0b sum=%0d want 1/0/13", m_ov, m_oo, m_os); end
        if (m_st !== 1'b1) begin n_fail++; $display("FAIL basic_state: got %0b want 1", m_st); end
        step(fi, fo);
        n_tests += 2;
        if (!fo) begin n_fail++; $display("FAIL basic_fire: result not handed over"); end
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL basic_drain: out_valid=%0b want 0", m_ov); end
        model_reset();
    endtask

    task automatic test_directed(input int s, input logic [7:0] d0, input logic [7:0] d1,
                                 input int n, input logic [8:0] want, input string name);
        bit fi, fo;
        int k;
        sel = s;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = (i == n - 1) ? d1 : d0;
            step(fi, fo);
        end
        in_valid = 1'b0;
        k = 0;
        while (!m_ov && k < 5) begin step(fi, fo); k++; end
        n_tests++;
        if ({m_ov, m_oo, m_os} !== {1'b1, want})
            begin n_fail++; $display("FAIL %s: valid=%0b ovf=%0b sum=%0d want 1/%0b/%0d", name, m_ov, m_oo, m_os, want[8], want[7:0]); end
        step(fi, fo);
        model_reset();
    endtask

    task automatic test_back_to_back(input int s, input int ncyc, input string name);
        bit fi, fo;
        int k;
        sel = s;
        do_reset();
        for (int c = 0; c < ncyc + 20; c++) begin
            in_valid = (c < ncyc) && ($urandom_range(0, 9) < 8);
            in_data = 8'($urandom);
            out_ready = (c >= ncyc) || ($urandom_range(0, 9) < 7);
            if (m_ov) begin
                n_tests++;
                if (exp_q.size() == 0)
                    begin n_fail++; $display("FAIL %s_extra: out_valid with sum=%0d, want no result", name, m_os); end
                else if ({m_oo, m_os} !== exp_q[0])
                    begin n_fail++; $display("FAIL %s_result: ovf=%0b sum=%0d want %0b/%0d", name, m_oo, m_os, exp_q[0][8], exp_q[0][7:0]); end
            end
            step(fi, fo);
            if (fo && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        k = exp_q.size();
        n_tests++;
        if (k != 0) begin n_fail++; $display("FAIL %s_lost: %0d results never delivered, want 0", name, k); end
    endtask

    task automatic test_backpressure();
        bit fi, fo;
        int fires, cyc, pops;
        sel = 0;
        do_reset();
        fires = 0; cyc = 0;
        while (cyc < 14) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            if (m_ov) begin
                n_tests++;
                if (exp_q.size() == 0 || {m_oo, m_os} !== exp_q[0])
                    begin n_fail++; $display("FAIL bp_hold: ovf=%0b sum=%0d not the expected held result", m_oo, m_os); end
            end
            step(fi, fo);
            if (fi) fires++;
            cyc++;
        end
        n_tests += 2;
        if (fires != 8) begin n_fail++; $display("FAIL bp_fires: %0d samples accepted, want 8", fires); end
        if (m_ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", m_ir); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_ov) begin
                n_tests++;
                if (exp_q.size() == 0 || {m_oo, m_os} !== exp_q[0])
                    begin n_fail++; $display("FAIL bp_order: ovf=%0b sum=%0d out of order or unexpected", m_oo, m_os); end
            end
            step(fi, fo);
            if (fo && exp_q.size() > 0) begin void'(exp_q.pop_front()); pops++; end
        end
        n_tests++;
        if (pops != 2) begin n_fail++; $display("FAIL bp_count: %0d results delivered, want 2", pops); end
    endtask

    task automatic test_clear();
        bit fi, fo;
        int fires, cyc, pops;
        logic [8:0] first;
        sel = 0;
        do_reset();
        fires = 0; cyc = 0;
        while (fires < 6 && cyc < 15) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            step(fi, fo);
            if (fi) fires++;
            cyc++;
        end
        first = exp_q.size() > 0 ? exp_q[0] : 9'h1FF;
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        step(fi, fo);
        n_tests += 3;
        if (fires != 6) begin n_fail++; $display("FAIL clr_setup: %0d samples accepted, want 6", fires); end
        if (fi) begin n_fail++; $display("FAIL clr_accept: sample accepted during clear, want refused"); end
        if ({m_ov, m_oo, m_os} !== {1'b1, first})
            begin n_fail++; $display("FAIL clr_pending: valid=%0b ovf=%0b sum=%0d want 1/%0b/%0d", m_ov, m_oo, m_os, first[8], first[7:0]); end
        model_clear();
        clear = 1'b0;
        fires = 0; cyc = 0;
        while (fires < 4 && cyc < 10) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            step(fi, fo);
            if (fi) fires++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_ov) begin
                n_tests++;
                if (exp_q.size() == 0 || {m_oo, m_os} !== exp_q[0])
                    begin n_fail++; $display("FAIL clr_result: ovf=%0b sum=%0d not the expected result", m_oo, m_os); end
            end
            step(fi, fo);
            if (fo && exp_q.size() > 0) begin void'(exp_q.pop_front()); pops++; end
        end
        n_tests++;
        if (pops != 2) begin n_fail++; $display("FAIL clr_count: %0d results delivered, want 2", pops); end
    endtask

    task automatic test_reset_mid();
        bit fi, fo;
        int pops;
        sel = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            step(fi, fo);
        end
        reset_ = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if (m_ov !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b want 0", m_ov); end
        if (m_os !== 8'd0) begin n_fail++; $display("FAIL rst_mid_sum: got %0d want 0", m_os); end
        if (m_ir !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %0b want 0", m_ir); end
        reset_ = 1'b1;
        model_reset();
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4); in_data = 8'($urandom);
            if (m_ov) begin
                n_tests++;
                if (exp_q.size() == 0 || {m_oo, m_os} !== exp_q[0])
                    begin n_fail++; $display("FAIL rst_fresh: ovf=%0b sum=%0d not the fresh window", m_oo, m_os); end
            end
            step(fi, fo);
            if (fo && exp_q.size() > 0) begin void'(exp_q.pop_front()); pops++; end
        end
        n_tests++;
        if (pops != 1) begin n_fail++; $display("FAIL rst_count: %0d results delivered, want 1", pops); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        sel = 0;
        reset_ = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_directed(1, 8'hFF, 8'hFF, 4, SAT ? {1'b1, 8'd31} : {1'b1, 8'd0}, "overflow");
        test_directed(2, 8'h00, 8'hF0, 2, {1'b0, 8'd12}, "act_low");
        test_directed(3, 8'h00, 8'hB5, 1, {1'b0, 8'd5}, "window1");
        test_back_to_back(0, 200, "rand_w4");
        test_back_to_back(1, 150, "rand_ovf");
        test_back_to_back(3, 60, "rand_w1");
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
